// File: rtl/ex_stage.sv
// ex_stage: execute stage (ALU, branch target/compare, EX/MEM register feeding MEM).
// Define EX_MULDIV_EN to build the iterative multiply/divide unit for ops 12..14.
module ex_stage
`ifdef EX_MULDIV_EN
#(
  parameter int MD_CYCLES = 32
)
`endif
(
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [31:0] IDEX_pc_i,
  input  logic [31:0] IDEX_a_i,
  input  logic [31:0] IDEX_b_i,
  input  logic [31:0] IDEX_imm_i,
  input  logic [4:0]  IDEX_rt_i,
  input  logic [4:0]  IDEX_rd_i,
  input  logic [3:0]  IDEX_ctrl_alu_op_i,
  input  logic        IDEX_ctrl_alu_src_i,
  input  logic        IDEX_ctrl_reg_dst_i,
  input  logic        IDEX_ctrl_branch_i,
  input  logic        IDEX_ctrl_branch_ne_i,
  input  logic [1:0]  IDEX_ctrl_mem_read_i,
  input  logic [1:0]  IDEX_ctrl_mem_write_i,
  input  logic        IDEX_ctrl_reg_write_i,
  input  logic        IDEX_ctrl_mem_to_reg_i,
  input  logic        EX_flush_i,
  output logic [31:0] EXMEM_pc_branch_o,
  output logic [31:0] EXMEM_alu_o,
  output logic        EXMEM_alu_do_branch_o,
  output logic [31:0] EXMEM_b_o,
  output logic [4:0]  EXMEM_reg_write_address_o,
  output logic        EXMEM_ctrl_branch_o,
  output logic [1:0]  EXMEM_ctrl_mem_read_o,
  output logic [1:0]  EXMEM_ctrl_mem_write_o,
  output logic        EXMEM_ctrl_reg_write_o,
  output logic        EXMEM_ctrl_mem_to_reg_o,
  output logic        EX_stall_o,
  output logic [1:0]  dbg_md_state_o
);

  // Stall handshake: while EX_stall_o is high, PC, IF/ID and ID/EX hold their contents, so the
  // EX instruction stays put and EX/MEM receives bubbles; the op moves on once stall drops.
  logic [31:0] op_b, alu_res, ex_res;
  logic        stall, bubble;

  assign op_b = IDEX_ctrl_alu_src_i ? IDEX_imm_i : IDEX_b_i;

  always_comb begin
    alu_res = '0;
    case (IDEX_ctrl_alu_op_i)
      4'd0:    alu_res = IDEX_a_i + op_b;
      4'd1:    alu_res = IDEX_a_i - op_b;
      4'd2:    alu_res = IDEX_a_i & op_b;
      4'd3:    alu_res = IDEX_a_i | op_b;
      4'd4:    alu_res = IDEX_a_i ^ op_b;
      4'd5:    alu_res = ~(IDEX_a_i | op_b);
      4'd6:    alu_res = {31'd0, ($signed(IDEX_a_i) < $signed(op_b))};
      4'd7:    alu_res = {31'd0, (IDEX_a_i < op_b)};
      4'd8:    alu_res = op_b << IDEX_a_i[4:0];
      4'd9:    alu_res = op_b >> IDEX_a_i[4:0];
      4'd10:   alu_res = $unsigned($signed(op_b) >>> IDEX_a_i[4:0]);
      4'd11:   alu_res = {op_b[15:0], 16'h0000};
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} md_state_e;
  localparam int CNT_W = $clog2(MD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       md_op_q;
  // mul: product / multiplicand / multiplier; div: remainder / dividend->quotient / divisor
  logic [31:0]      acc_q, sh_q, opd_q;
  logic [32:0]      trial, diff;
  logic             is_md;

  assign is_md = (IDEX_ctrl_alu_op_i >= 4'd12) && (IDEX_ctrl_alu_op_i <= 4'd14);
  assign trial = {acc_q, sh_q[31]};
  assign diff  = trial - {1'b0, opd_q};

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      MD_IDLE: if (is_md) begin
        stall   = 1'b1;
        state_d = MD_BUSY;
      end
      MD_BUSY: begin
        stall = 1'b1;
        if (cnt_q == CNT_LAST) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (EX_flush_i || !n_rst_i) begin
      state_d = MD_IDLE;
      stall   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      md_op_q <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MD_IDLE && is_md) begin
        cnt_q   <= '0;
        md_op_q <= IDEX_ctrl_alu_op_i;
        acc_q   <= '0;
        sh_q    <= IDEX_a_i;
        opd_q   <= op_b;
      end else if (state_q == MD_BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (md_op_q == 4'd12) begin
          if (opd_q[0]) acc_q <= acc_q + sh_q;
          sh_q  <= sh_q << 1;
          opd_q <= opd_q >> 1;
        end else if (!diff[32]) begin
          // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
          acc_q <= diff[31:0];
          sh_q  <= {sh_q[30:0], 1'b1};
        end else begin
          acc_q <= trial[31:0];
          sh_q  <= {sh_q[30:0], 1'b0};
        end
      end
    end
  end

  assign ex_res = (state_q != MD_DONE) ? alu_res : (md_op_q == 4'd13) ? sh_q : acc_q;
  assign dbg_md_state_o = state_q;
`else
  assign stall          = 1'b0;
  assign ex_res         = alu_res;
  assign dbg_md_state_o = 2'b00;
`endif

  assign EX_stall_o = stall;
  assign bubble     = EX_flush_i | stall;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i || bubble) begin
      EXMEM_pc_branch_o         <= '0;
      EXMEM_alu_o               <= '0;
      EXMEM_alu_do_branch_o     <= 1'b0;
      EXMEM_b_o                 <= '0;
      EXMEM_reg_write_address_o <= '0;
      EXMEM_ctrl_branch_o       <= 1'b0;
      EXMEM_ctrl_mem_read_o     <= '0;
      EXMEM_ctrl_mem_write_o    <= '0;
      EXMEM_ctrl_reg_write_o    <= 1'b0;
      EXMEM_ctrl_mem_to_reg_o   <= 1'b0;
    end else begin
      EXMEM_pc_branch_o         <= IDEX_pc_i + (IDEX_imm_i << 2);
      EXMEM_alu_o               <= ex_res;
      EXMEM_alu_do_branch_o     <= (IDEX_a_i == IDEX_b_i) ^ IDEX_ctrl_branch_ne_i;
      EXMEM_b_o                 <= IDEX_b_i;
      EXMEM_reg_write_address_o <= IDEX_ctrl_reg_dst_i ? IDEX_rd_i : IDEX_rt_i;
      EXMEM_ctrl_branch_o       <= IDEX_ctrl_branch_i;
      EXMEM_ctrl_mem_read_o     <= IDEX_ctrl_mem_read_i;
      EXMEM_ctrl_mem_write_o    <= IDEX_ctrl_mem_write_i;
      EXMEM_ctrl_reg_write_o    <= IDEX_ctrl_reg_write_i;
      EXMEM_ctrl_mem_to_reg_o   <= IDEX_ctrl_mem_to_reg_i;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed table of ALU/branch vectors plus hand sequences for ctrl pass-through,
// flush, and (with EX_MULDIV_EN) multi-cycle mul/div, mid-op flush and mid-op reset.
module tb_ex_stage;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_NOR = 4'd5, OP_SLT = 4'd6, OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8, OP_SRL = 4'd9, OP_SRA = 4'd10, OP_LUI = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12, OP_DIVU = 4'd13, OP_REMU = 4'd14, OP_15 = 4'd15;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic [31:0] pc, a, b, imm;
  logic [4:0]  rt, rd;
  logic [3:0]  alu_op;
  logic        alu_src, reg_dst, branch, branch_ne, reg_write, mem_to_reg, flush;
  logic [1:0]  mem_read, mem_write;
  logic [31:0] pcb_o, alu_o, b_o;
  logic        do_br_o, br_o, rw_o, m2r_o, stall_o;
  logic [4:0]  addr_o;
  logic [1:0]  mr_o, mw_o, dbg_o;

  always #5 clk_i = ~clk_i;

  ex_stage dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i),
    .IDEX_pc_i(pc), .IDEX_a_i(a), .IDEX_b_i(b), .IDEX_imm_i(imm),
    .IDEX_rt_i(rt), .IDEX_rd_i(rd),
    .IDEX_ctrl_alu_op_i(alu_op), .IDEX_ctrl_alu_src_i(alu_src), .IDEX_ctrl_reg_dst_i(reg_dst),
    .IDEX_ctrl_branch_i(branch), .IDEX_ctrl_branch_ne_i(branch_ne),
    .IDEX_ctrl_mem_read_i(mem_read), .IDEX_ctrl_mem_write_i(mem_write),
    .IDEX_ctrl_reg_write_i(reg_write), .IDEX_ctrl_mem_to_reg_i(mem_to_reg),
    .EX_flush_i(flush),
    .EXMEM_pc_branch_o(pcb_o), .EXMEM_alu_o(alu_o), .EXMEM_alu_do_branch_o(do_br_o),
    .EXMEM_b_o(b_o), .EXMEM_reg_write_address_o(addr_o),
    .EXMEM_ctrl_branch_o(br_o), .EXMEM_ctrl_mem_read_o(mr_o), .EXMEM_ctrl_mem_write_o(mw_o),
    .EXMEM_ctrl_reg_write_o(rw_o), .EXMEM_ctrl_mem_to_reg_o(m2r_o),
    .EX_stall_o(stall_o), .dbg_md_state_o(dbg_o)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] op, input logic [31:0] ia, ib, iimm, ipc,
                       input logic src, ne, dst);
    alu_op = op; a = ia; b = ib; imm = iimm; pc = ipc;
    alu_src = src; branch_ne = ne; reg_dst = dst;
    rt = 5'd9; rd = 5'd17;
    branch = 1'b0; mem_read = 2'b00; mem_write = 2'b00; reg_write = 1'b1; mem_to_reg = 1'b0;
  endtask

  task automatic drive_nop();
    drive(OP_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    reg_write = 1'b0;
  endtask

`ifdef EX_MULDIV_EN
  // Issue one mul/div op, count stalled cycles, check bubbles, then check the captured result.
  task automatic run_md(input string nm, input logic [3:0] op, input logic [31:0] ia, ib,
                        input logic [31:0] exp);
    int n = 0;
    int bad = 0;
    drive(op, ia, ib, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(exp);
    #1;
    while (stall_o === 1'b1 && n < 100) begin
      @(posedge clk_i); #1;
      n++;
      if (rw_o !== 1'b0 || alu_o !== 32'd0) bad++;
    end
    chk({nm, "_stall_cycles"}, n, 33);
    chk({nm, "_bubbles"}, bad, 0);
    @(posedge clk_i); #1;
    chk({nm, "_result"}, alu_o, exp_q.pop_front());
    chk({nm, "_reg_write"}, rw_o, 1);
    chk({nm, "_addr"}, addr_o, 17);
  endtask
`endif

  // ---------------- vector table ----------------
  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a, b, imm, pc;
    logic        src, ne, dst;
    logic [31:0] exp_alu;
    logic        exp_br;
    logic [31:0] exp_pcb;
    logic [4:0]  exp_addr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"add_imm", OP_ADD, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'h1000, 1, 0, 0,
                     32'd2, 0, 32'h0FF4, 5'd9});
    vecs.push_back('{"beq", OP_SUB, 32'd7, 32'd7, 32'd4, 32'h100, 0, 0, 0,
                     32'd0, 1, 32'h110, 5'd9});
    vecs.push_back('{"bne", OP_SUB, 32'd7, 32'd7, 32'd4, 32'h100, 0, 1, 0,
                     32'd0, 0, 32'h110, 5'd9});
    vecs.push_back('{"add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 0, 1,
                     32'h8000_0000, 0, 32'd0, 5'd17});
    vecs.push_back('{"sub_wrap", OP_SUB, 32'd0, 32'd1, 32'd0, 32'd0, 0, 1, 1,
                     32'hFFFF_FFFF, 1, 32'd0, 5'd17});
    vecs.push_back('{"and", OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0, 0, 0, 0,
                     32'h00F0_00F0, 0, 32'd0, 5'd9});
    vecs.push_back('{"or", OP_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0, 0, 0, 1,
                     32'hFFF0_FFF0, 0, 32'd0, 5'd17});
    vecs.push_back('{"xor", OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0, 0, 0, 0,
                     32'hFF00_FF00, 0, 32'd0, 5'd9});
    vecs.push_back('{"nor", OP_NOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0, 0, 0, 1,
                     32'h000F_000F, 0, 32'd0, 5'd17});
    vecs.push_back('{"slt_t", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 0, 0,
                     32'd1, 0, 32'd0, 5'd9});
    vecs.push_back('{"slt_f", OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 0, 0,
                     32'd0, 0, 32'd0, 5'd9});
    vecs.push_back('{"sltu_f", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 0, 0,
                     32'd0, 0, 32'd0, 5'd9});
    vecs.push_back('{"sltu_t", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 0, 0,
                     32'd1, 0, 32'd0, 5'd9});
    vecs.push_back('{"sll", OP_SLL, 32'd31, 32'd1, 32'd0, 32'd0, 0, 0, 0,
                     32'h8000_0000, 0, 32'd0, 5'd9});
    vecs.push_back('{"srl", OP_SRL, 32'd4, 32'h8000_0000, 32'd0, 32'd0, 0, 0, 0,
                     32'h0800_0000, 0, 32'd0, 5'd9});
    vecs.push_back('{"sra", OP_SRA, 32'h24, 32'h8000_0000, 32'd0, 32'd0, 0, 0, 0,
                     32'hF800_0000, 0, 32'd0, 5'd9});
    vecs.push_back('{"lui", OP_LUI, 32'd0, 32'd0, 32'h1234, 32'd0, 1, 0, 0,
                     32'h1234_0000, 1, 32'h48D0, 5'd9});
    vecs.push_back('{"op15", OP_15, 32'd5, 32'd5, 32'd0, 32'd0, 0, 1, 0,
                     32'd0, 0, 32'd0, 5'd9});
`ifndef EX_MULDIV_EN
    vecs.push_back('{"mul_off", OP_MUL, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 0, 0, 0,
                     32'd0, 0, 32'd0, 5'd9});
    vecs.push_back('{"divu_off", OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 0, 0, 0,
                     32'd0, 0, 32'd0, 5'd9});
`endif
  end

  // ---------------- test sequence ----------------
  initial begin
    n_rst_i = 1'b0;
    flush   = 1'b0;
    drive_nop();
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_alu", alu_o, 0);
    chk("reset_pcb", pcb_o, 0);
    chk("reset_reg_write", rw_o, 0);
    chk("reset_stall", stall_o, 0);
    chk("reset_state", dbg_o, 0);
    n_rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Table-driven single-cycle vectors
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc,
            vecs[i].src, vecs[i].ne, vecs[i].dst);
      exp_q.push_back(vecs[i].exp_alu);
      #1;
      chk({vecs[i].nm, "_stall"}, stall_o, 0);
      @(posedge clk_i); #1;
      chk({vecs[i].nm, "_alu"}, alu_o, exp_q.pop_front());
      chk({vecs[i].nm, "_do_branch"}, do_br_o, vecs[i].exp_br);
      chk({vecs[i].nm, "_pc_branch"}, pcb_o, vecs[i].exp_pcb);
      chk({vecs[i].nm, "_addr"}, addr_o, vecs[i].exp_addr);
    end

    // Control pass-through, then a flush of the same instruction
    drive(OP_ADD, 32'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFD, 32'd0, 1'b1, 1'b0, 1'b0);
    branch = 1'b1; mem_read = 2'b01; mem_write = 2'b10; mem_to_reg = 1'b1;
    @(posedge clk_i); #1;
    chk("pt_alu", alu_o, 2);
    chk("pt_b", b_o, 32'hDEAD_BEEF);
    chk("pt_branch", br_o, 1);
    chk("pt_mem_read", mr_o, 2'b01);
    chk("pt_mem_write", mw_o, 2'b10);
    chk("pt_reg_write", rw_o, 1);
    chk("pt_mem_to_reg", m2r_o, 1);
    flush = 1'b1;
    @(posedge clk_i); #1;
    flush = 1'b0;
    chk("flush_alu", alu_o, 0);
    chk("flush_b", b_o, 0);
    chk("flush_branch", br_o, 0);
    chk("flush_mem_read", mr_o, 0);
    chk("flush_reg_write", rw_o, 0);
    chk("flush_mem_to_reg", m2r_o, 0);

`ifdef EX_MULDIV_EN
    // Back-to-back mul/div ops, including divide by zero
    run_md("mul", OP_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    run_md("divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
    run_md("remu", OP_REMU, 32'd100, 32'd7, 32'd2);
    run_md("divu0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_md("remu0", OP_REMU, 32'd5, 32'd0, 32'd5);
    drive_nop();
    @(posedge clk_i); #1;

    // Flush at BUSY count 10
    drive(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    repeat (11) @(posedge clk_i);
    #1;
    chk("mdflush_pre_state", dbg_o, 1);
    chk("mdflush_pre_stall", stall_o, 1);
    flush = 1'b1;
    #1;
    chk("mdflush_stall_comb", stall_o, 0);
    @(posedge clk_i); #1;
    flush = 1'b0;
    drive_nop();
    #1;
    chk("mdflush_state", dbg_o, 0);
    chk("mdflush_stall", stall_o, 0);
    chk("mdflush_reg_write", rw_o, 0);
    chk("mdflush_alu", alu_o, 0);
    run_md("mul_after_flush", OP_MUL, 32'd6, 32'd7, 32'd42);
    drive_nop();
    @(posedge clk_i); #1;

    // Reset at BUSY count 10
    drive(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    repeat (11) @(posedge clk_i);
    #1;
    chk("mdrst_pre_stall", stall_o, 1);
    n_rst_i = 1'b0;
    #1;
    chk("mdrst_stall", stall_o, 0);
    chk("mdrst_state", dbg_o, 0);
    chk("mdrst_alu", alu_o, 0);
    chk("mdrst_reg_write", rw_o, 0);
    chk("mdrst_addr", addr_o, 0);
    drive_nop();
    @(posedge clk_i); #1;
    n_rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("mdrst_no_partial", rw_o, 0);
    run_md("mul_after_reset", OP_MUL, 32'd6, 32'd7, 32'd42);
    drive_nop();
    @(posedge clk_i); #1;
`else
    drive(OP_MUL, 32'd6, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("mul_off_stall", stall_o, 0);
    chk("mul_off_state", dbg_o, 0);
    @(posedge clk_i); #1;
    chk("mul_off_result", alu_o, 0);
    chk("mul_off_reg_write", rw_o, 1);
`endif

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
